// File: rtl/psum_tree_pkg.sv
// Shared types and helpers for the partial-sum adder tree controller.
package psum_tree_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  function automatic int tree_lat(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/psum_tag_pipe.sv
// Tag shift register that rides alongside the adder tree pipeline.
// It advances exactly when the tree does, so the head tag always describes tree_sum.
module psum_tag_pipe
  import psum_tree_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  tag_t tag_in,
  output tag_t head,
  output logic any_vld
);

  tag_t tag_p [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) tag_p[i] <= '0;
    end else if (en) begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < STAGES; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign head = tag_p[STAGES-1];

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < STAGES; i++) any_vld = any_vld | tag_p[i].vld;
  end

endmodule

// File: rtl/psum_tree_ctrl.sv
// Stream sequencer and wide accumulator around an external pipelined adder tree.
// Define ACC_SATURATE_EN to clamp the accumulator and flag saturated vectors on m_sat.
module psum_tree_ctrl
  import psum_tree_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pINPUT_NUM  = 32,
  parameter int pACC_WIDTH  = 48,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [pDATA_WIDTH*pINPUT_NUM-1:0] s_data,
  input  logic                              s_last,
  output logic                              tree_en,
  output logic [pDATA_WIDTH*pINPUT_NUM-1:0] tree_data,
  input  logic signed [pDATA_WIDTH-1:0]     tree_sum,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic signed [pACC_WIDTH-1:0]      m_data,
  output logic [pCNT_WIDTH-1:0]             m_beats,
  output logic                              m_sat,
  output logic                              busy
);

  localparam int LAT = tree_lat(pINPUT_NUM);
  localparam int AW1 = pACC_WIDTH + 1;

  state_e state, state_nxt;
  tag_t   head;
  logic   any_vld;
  logic   advance, accept, consume;

  logic                         first_p0;
  logic signed [pACC_WIDTH-1:0] acc_p0, acc_base, acc_n;
  logic [pCNT_WIDTH-1:0]        cnt_p0, cnt_base, cnt_n;

  function automatic logic [pCNT_WIDTH-1:0] cnt_inc(input logic [pCNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // The whole pipe freezes while a result is stuck at the output; reset also stalls it.
  assign advance   = !rst && (!m_valid || m_ready);
  assign accept    = s_valid && advance;
  assign s_ready   = advance;
  assign tree_en   = advance;
  assign tree_data = s_data;
  assign consume   = advance && head.vld;

  psum_tag_pipe #(.STAGES(LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (advance),
    .tag_in  ('{vld: accept, last: s_last}),
    .head    (head),
    .any_vld (any_vld)
  );

  assign acc_base = first_p0 ? '0 : acc_p0;
  assign cnt_base = first_p0 ? '0 : cnt_p0;
  assign cnt_n    = cnt_inc(cnt_base);

`ifdef ACC_SATURATE_EN
  logic signed [AW1-1:0] acc_sum;
  logic                  sat_p0, sat_n;

  function automatic logic signed [pACC_WIDTH-1:0] acc_clamp(input logic signed [AW1-1:0] s);
    if (s[AW1-1] != s[AW1-2])
      return s[AW1-1] ? {1'b1, {(pACC_WIDTH-1){1'b0}}} : {1'b0, {(pACC_WIDTH-1){1'b1}}};
    return s[pACC_WIDTH-1:0];
  endfunction

  assign acc_sum = AW1'(acc_base) + AW1'(tree_sum);
  assign acc_n   = acc_clamp(acc_sum);
  assign sat_n   = (!first_p0 && sat_p0) || (acc_sum[AW1-1] != acc_sum[AW1-2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_p0 <= 1'b0;
      m_sat  <= 1'b0;
    end else if (consume) begin
      if (head.last) m_sat  <= sat_n;
      else           sat_p0 <= sat_n;
    end
  end
`else
  assign acc_n = acc_base + pACC_WIDTH'(tree_sum);
  assign m_sat = 1'b0;
`endif

  // Head stage: fold the tree output into the running vector sum
  always_ff @(posedge clk) begin
    if (rst) begin
      first_p0 <= 1'b1;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_beats  <= '0;
    end else if (advance) begin
      m_valid <= consume && head.last;
      if (consume) begin
        if (head.last) begin
          m_data   <= acc_n;
          m_beats  <= cnt_n;
          first_p0 <= 1'b1;
        end else begin
          acc_p0   <= acc_n;
          cnt_p0   <= cnt_n;
          first_p0 <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (m_valid && !m_ready)
          state_nxt = HOLD;
        else if (!any_vld && first_p0 && !m_valid && !accept)
          state_nxt = IDLE;
      end
      HOLD:    if (m_ready) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
